// File: rtl/stm_swapchain_n_pkg.sv
// Shared constants for the STM swapchain: transition trigger modes and a
// helper that tells whether a mode byte is one the swapchain understands.
package stm_swapchain_n_pkg;

  localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
  localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

  function automatic logic is_valid_mode(input logic [7:0] mode);
    return (mode == TRANSITION_MODE_SYNC_IDX)  ||
           (mode == TRANSITION_MODE_SYS_TIME)  ||
           (mode == TRANSITION_MODE_GPIO)      ||
           (mode == TRANSITION_MODE_IMMEDIATE);
  endfunction

endpackage

// File: rtl/addsub_64_64.sv
// Registered 64-bit add/subtract with a 65-bit signed result; operands are
// zero-extended so the sign bit of a subtraction means a < b.
module addsub_64_64 (
  input  logic               clk,
  input  logic               rst,
  input  logic               sub,
  input  logic [63:0]        a,
  input  logic [63:0]        b,
  output logic signed [64:0] result
);

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (sub) begin
      result <= $signed({1'b0, a}) - $signed({1'b0, b});
    end else begin
      result <= $signed({1'b0, a}) + $signed({1'b0, b});
    end
  end

endmodule

// File: rtl/stm_swapchain_n.sv
// Segment switch arbiter for the STM engine: holds a transition request until
// its trigger fires, counts finite repetitions and drives per-segment indices.
module stm_swapchain_n
  import stm_swapchain_n_pkg::*;
#(
  parameter int NUM_SEGMENTS = 2,
  parameter int IDX_WIDTH    = 16,
  parameter int REP_WIDTH    = 32,
  parameter int NUM_GPIO     = 4,
  localparam int SEG_W  = (NUM_SEGMENTS > 2) ? $clog2(NUM_SEGMENTS) : 1,
  localparam int GPIO_W = (NUM_GPIO > 2) ? $clog2(NUM_GPIO) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [63:0]          SYS_TIME,
  input  logic                 UPDATE_SETTINGS,
  input  logic [SEG_W-1:0]     REQ_RD_SEGMENT,
  input  logic [7:0]           TRANSITION_MODE,
  input  logic [63:0]          TRANSITION_VALUE,
  input  logic [IDX_WIDTH-1:0] CYCLE    [NUM_SEGMENTS],
  input  logic [REP_WIDTH-1:0] REP      [NUM_SEGMENTS],
  input  logic [IDX_WIDTH-1:0] SYNC_IDX [NUM_SEGMENTS],
  input  logic [NUM_GPIO-1:0]  GPIO_IN,
  output logic                 STOP,
  output logic [SEG_W-1:0]     SEGMENT,
  output logic [IDX_WIDTH-1:0] IDX      [NUM_SEGMENTS],
  output logic                 PENDING,
  output logic                 LOOP_DONE
);

  typedef enum logic [1:0] {
    INFINITE_LOOP,
    WAIT_START,
    FINITE_LOOP
  } state_t;

  typedef enum logic {
    SYNC,
    TIC
  } idx_mode_t;

  state_t                 state;
  idx_mode_t              idx_mode;
  logic [IDX_WIDTH-1:0]   tic_idx [NUM_SEGMENTS];
  logic [IDX_WIDTH-1:0]   idx_old [NUM_SEGMENTS];
  logic [REP_WIDTH-1:0]   loop_cnt;
  logic [REP_WIDTH-1:0]   rep_l;
  logic [7:0]             mode_l;
  logic [63:0]            value_l;
  logic [SEG_W-1:0]       req_l;
  logic                   diff_valid;
  logic signed [64:0]     diff;

  logic [NUM_SEGMENTS-1:0] changed;
  logic                    req_ok;
  logic                    fire;
  logic                    fire_tic;
  logic                    pass_end;
  logic                    gpio_in_range;

  // Latched value minus current time; negative once the target time has passed.
  addsub_64_64 u_time_diff (
    .clk    (CLK),
    .rst    (RST),
    .sub    (1'b1),
    .a      (value_l),
    .b      (SYS_TIME),
    .result (diff)
  );

  always_comb begin
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      changed[s] = (idx_old[s] != SYNC_IDX[s]);
    end
  end

  assign req_ok        = UPDATE_SETTINGS && (32'(REQ_RD_SEGMENT) < NUM_SEGMENTS) &&
                         is_valid_mode(TRANSITION_MODE);
  assign gpio_in_range = (value_l < 64'(NUM_GPIO));

  always_comb begin
    fire     = 1'b0;
    fire_tic = 1'b0;
    case (mode_l)
      TRANSITION_MODE_SYNC_IDX: begin
        fire = changed[req_l] && (SYNC_IDX[req_l] == '0);
      end
      TRANSITION_MODE_SYS_TIME: begin
        fire     = diff_valid && diff[64];
        fire_tic = 1'b1;
      end
      TRANSITION_MODE_GPIO: begin
        fire     = changed[req_l] && gpio_in_range && GPIO_IN[value_l[GPIO_W-1:0]];
        fire_tic = 1'b1;
      end
      TRANSITION_MODE_IMMEDIATE: begin
        fire = 1'b1;
      end
      default: begin
        fire = 1'b0;
      end
    endcase
  end

  // A pass ends on the segment's own wrap (SYNC) or on the tick after the last index (TIC).
  always_comb begin
    if (idx_mode == TIC) begin
      pass_end = (tic_idx[SEGMENT] == CYCLE[SEGMENT]);
    end else begin
      pass_end = (SYNC_IDX[SEGMENT] == '0);
    end
  end

  always_ff @(posedge CLK) begin
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      idx_old[s] <= RST ? '0 : SYNC_IDX[s];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= INFINITE_LOOP;
      idx_mode   <= SYNC;
      SEGMENT    <= '0;
      STOP       <= 1'b0;
      PENDING    <= 1'b0;
      LOOP_DONE  <= 1'b0;
      loop_cnt   <= '0;
      rep_l      <= '0;
      mode_l     <= '0;
      value_l    <= '0;
      req_l      <= '0;
      diff_valid <= 1'b0;
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        tic_idx[s] <= '0;
      end
    end else begin
      LOOP_DONE <= 1'b0;
      if (req_ok) begin
        if (REQ_RD_SEGMENT == SEGMENT) begin
          state    <= INFINITE_LOOP;
          PENDING  <= 1'b0;
          STOP     <= 1'b0;
          idx_mode <= SYNC;
        end else if (&REP[REQ_RD_SEGMENT]) begin
          state    <= INFINITE_LOOP;
          PENDING  <= 1'b0;
          STOP     <= 1'b0;
          idx_mode <= SYNC;
          SEGMENT  <= REQ_RD_SEGMENT;
        end else begin
          state      <= WAIT_START;
          PENDING    <= 1'b1;
          rep_l      <= REP[REQ_RD_SEGMENT];
          mode_l     <= TRANSITION_MODE;
          value_l    <= TRANSITION_VALUE;
          req_l      <= REQ_RD_SEGMENT;
          diff_valid <= 1'b0;
        end
      end else begin
        case (state)
          WAIT_START: begin
            diff_valid <= 1'b1;
            if (fire) begin
              state    <= FINITE_LOOP;
              PENDING  <= 1'b0;
              STOP     <= 1'b0;
              loop_cnt <= '0;
              SEGMENT  <= req_l;
              idx_mode <= fire_tic ? TIC : SYNC;
              if (fire_tic) begin
                tic_idx[req_l] <= '0;
              end
            end
          end
          FINITE_LOOP: begin
            if (changed[SEGMENT]) begin
              if (pass_end) begin
                if (idx_mode == TIC) begin
                  tic_idx[SEGMENT] <= '0;
                end
                if (loop_cnt == rep_l) begin
                  LOOP_DONE <= ~STOP;
                  STOP      <= 1'b1;
                end else begin
                  loop_cnt <= loop_cnt + 1'b1;
                end
              end else if (idx_mode == TIC) begin
                tic_idx[SEGMENT] <= tic_idx[SEGMENT] + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      if ((idx_mode == TIC) && (SEG_W'(s) == SEGMENT)) begin
        IDX[s] = tic_idx[s];
      end else begin
        IDX[s] = idx_old[s];
      end
    end
  end

endmodule

// File: tb/tb_stm_swapchain_n.sv
// Scoreboard bench for stm_swapchain_n: an event-level model predicts every
// cycle's outputs, a monitor compares them against the DUT on the falling edge.
module tb_stm_swapchain_n;

  localparam int NS = 5;
  localparam int IW = 8;
  localparam int RW = 8;
  localparam int NG = 4;

  typedef struct packed {
    int             tag;
    logic [2:0]     seg;
    logic           stop;
    logic           pend;
    logic           done;
    logic [NS*IW-1:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   sys_time;
  logic          update;
  logic [2:0]    req_seg;
  logic [7:0]    tmode;
  logic [63:0]   tvalue;
  logic [IW-1:0] cycle    [NS];
  logic [RW-1:0] rep      [NS];
  logic [IW-1:0] sync_idx [NS];
  logic [NG-1:0] gpio;
  logic          stop;
  logic [2:0]    segment;
  logic [IW-1:0] idx      [NS];
  logic          pending;
  logic          loop_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t exp_q[$];

  int per [NS];
  int tmr [NS];

  // Reference model state: phase 0 free-running, 1 waiting for trigger, 2 counting passes.
  int          m_seg, m_phase, m_tic, m_req, m_age, m_rep;
  bit          m_stop, m_done, m_tic_mode;
  longint      m_left;
  int          m_prev [NS];
  logic [7:0]  m_mode;
  logic [63:0] m_val, m_sys_prev;

  stm_swapchain_n #(
    .NUM_SEGMENTS(NS),
    .IDX_WIDTH(IW),
    .REP_WIDTH(RW),
    .NUM_GPIO(NG)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .SYS_TIME(sys_time),
    .UPDATE_SETTINGS(update),
    .REQ_RD_SEGMENT(req_seg),
    .TRANSITION_MODE(tmode),
    .TRANSITION_VALUE(tvalue),
    .CYCLE(cycle),
    .REP(rep),
    .SYNC_IDX(sync_idx),
    .GPIO_IN(gpio),
    .STOP(stop),
    .SEGMENT(segment),
    .IDX(idx),
    .PENDING(pending),
    .LOOP_DONE(loop_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_step();
    bit ch [NS];
    bit valid, fire, go_tic, pass_end;
    for (int s = 0; s < NS; s++) ch[s] = (m_prev[s] != int'(sync_idx[s]));
    m_done = 1'b0;
    if (rst) begin
      m_seg = 0; m_stop = 1'b0; m_phase = 0; m_tic_mode = 1'b0;
      m_tic = 0; m_age = 0; m_left = 0;
    end else begin
      valid = update && (int'(req_seg) < NS) &&
              (tmode inside {8'h00, 8'h01, 8'h02, 8'hFF});
      if (valid) begin
        if (int'(req_seg) == m_seg) begin
          m_phase = 0; m_stop = 1'b0; m_tic_mode = 1'b0;
        end else if (rep[req_seg] == '1) begin
          m_seg = int'(req_seg); m_phase = 0; m_stop = 1'b0; m_tic_mode = 1'b0;
        end else begin
          m_req = int'(req_seg); m_mode = tmode; m_val = tvalue;
          m_rep = int'(rep[req_seg]); m_phase = 1; m_age = 0;
        end
      end else if (m_phase == 1) begin
        fire = 1'b0;
        go_tic = 1'b0;
        case (m_mode)
          8'h00: fire = ch[m_req] && (sync_idx[m_req] == 0);
          8'h01: begin fire = (m_age >= 1) && (m_val < m_sys_prev); go_tic = 1'b1; end
          8'h02: begin fire = ch[m_req] && (m_val < NG) && gpio[m_val[1:0]]; go_tic = 1'b1; end
          default: fire = 1'b1;
        endcase
        if (fire) begin
          m_stop = 1'b0; m_left = longint'(m_rep) + 1; m_seg = m_req;
          m_phase = 2; m_tic_mode = go_tic;
          if (go_tic) m_tic = 0;
        end else begin
          m_age++;
        end
      end else if (m_phase == 2 && ch[m_seg]) begin
        if (m_tic_mode) begin
          pass_end = (m_tic == int'(cycle[m_seg]));
          m_tic = pass_end ? 0 : m_tic + 1;
        end else begin
          pass_end = (sync_idx[m_seg] == 0);
        end
        if (pass_end) begin
          m_left--;
          if (m_left == 0) begin
            m_stop = 1'b1;
            m_done = 1'b1;
          end
        end
      end
    end
    for (int s = 0; s < NS; s++) m_prev[s] = rst ? 0 : int'(sync_idx[s]);
    m_sys_prev = sys_time;
  endtask

  task automatic apply_stimulus();
    exp_t e;
    model_step();
    e.tag  = cyc + 1;
    e.seg  = 3'(m_seg);
    e.stop = m_stop;
    e.pend = (m_phase == 1);
    e.done = m_done;
    for (int s = 0; s < NS; s++)
      e.idx[s*IW +: IW] = (m_tic_mode && s == m_seg) ? IW'(m_tic) : IW'(m_prev[s]);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    update = 1'b0;
    sys_time = sys_time + 1;
    for (int s = 0; s < NS; s++) begin
      if (tmr[s] >= per[s] - 1) begin
        tmr[s] = 0;
        sync_idx[s] = (sync_idx[s] >= cycle[s]) ? '0 : sync_idx[s] + 1'b1;
      end else begin
        tmr[s]++;
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic request(int seg, logic [7:0] mode, logic [63:0] value);
    update  = 1'b1;
    req_seg = 3'(seg);
    tmode   = mode;
    tvalue  = value;
    apply_stimulus();
  endtask

  task automatic check_val(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  task automatic check_output(exp_t e);
    check_val("SEGMENT", 64'(segment), 64'(e.seg));
    check_val("STOP", 64'(stop), 64'(e.stop));
    check_val("PENDING", 64'(pending), 64'(e.pend));
    check_val("LOOP_DONE", 64'(loop_done), 64'(e.done));
    for (int s = 0; s < NS; s++)
      check_val($sformatf("IDX[%0d]", s), 64'(idx[s]), 64'(e.idx[s*IW +: IW]));
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.tag < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL stale_entry tag=%0d actual_cycle=%0d", e.tag, cyc);
      end else begin
        check_output(e);
      end
    end
  end

  initial begin
    rst = 1'b1; update = 1'b0; req_seg = '0; tmode = '0; tvalue = '0;
    sys_time = 64'd100; gpio = '0;
    for (int s = 0; s < NS; s++) begin
      cycle[s] = IW'(2 + (s % 3));
      rep[s] = RW'(1);
      sync_idx[s] = '0;
      per[s] = 1 + (s % 3);
      tmr[s] = 0;
      m_prev[s] = 0;
    end
    @(posedge clk);
    #1;
    run(3);
    rst = 1'b0;
    run(4);

    $display("[TB] immediate switch through all-ones repeat");
    rep[1] = '1;
    request(1, 8'h00, 64'd0);
    run(5);

    $display("[TB] SYNC_IDX trigger with two finite passes");
    rep[3] = RW'(1);
    request(3, 8'h00, 64'd0);
    run(80);

    $display("[TB] SYS_TIME trigger with TIC indexing");
    sys_time = 64'd990;
    rep[2] = RW'(2);
    request(2, 8'h01, 64'd1000);
    run(70);

    $display("[TB] GPIO trigger held low then released");
    rep[4] = RW'(1);
    gpio = 4'b0000;
    request(4, 8'h02, 64'd2);
    run(50);
    gpio = 4'b0100;
    run(40);

    $display("[TB] GPIO index out of range never fires");
    gpio = 4'b1111;
    rep[0] = RW'(1);
    request(0, 8'h02, 64'd7);
    run(60);
    request(m_seg, 8'h00, 64'd0);
    run(3);
    gpio = 4'b0000;

    $display("[TB] invalid mode and invalid segment are ignored");
    rep[1] = RW'(0);
    request(1, 8'h05, 64'd0);
    run(3);
    request(5, 8'h00, 64'd0);
    run(3);
    request(7, 8'hFF, 64'd0);
    run(3);

    $display("[TB] reset after STOP and reset while pending");
    rep[2] = RW'(0);
    request(2, 8'hFF, 64'd0);
    run(40);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);
    rep[1] = RW'(1);
    request(1, 8'h02, 64'd7);
    run(5);
    rst = 1'b1;
    request(3, 8'hFF, 64'd0);
    rst = 1'b0;
    run(3);

    $display("[TB] randomized requests");
    for (int it = 0; it < 250; it++) begin
      int idle;
      int seg;
      logic [7:0] mode;
      logic [63:0] value;
      idle = $urandom_range(0, 15);
      for (int i = 0; i < idle; i++) begin
        gpio = NG'($urandom);
        apply_stimulus();
      end
      case ($urandom_range(0, 3))
        0: mode = 8'h00;
        1: mode = 8'h01;
        2: mode = 8'h02;
        default: mode = 8'hFF;
      endcase
      seg = $urandom_range(0, NS - 1);
      if (m_phase == 0 && $urandom_range(0, 9) == 0) seg = $urandom_range(NS, 7);
      if (m_phase == 0 && $urandom_range(0, 9) == 0) mode = 8'($urandom_range(3, 254));
      if (seg < NS) rep[seg] = ($urandom_range(0, 4) == 0) ? '1 : RW'($urandom_range(0, 3));
      if (mode == 8'h01) value = sys_time + 64'($urandom_range(0, 40));
      else if (mode == 8'h02) value = 64'($urandom_range(0, 5));
      else value = {$urandom, $urandom};
      gpio = NG'($urandom);
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
      request(seg, mode, value);
      rst = 1'b0;
    end
    run(20);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
